// File: rtl/fetch_buffer.sv
// fetch_buffer: 2-wide in-order instruction queue between fetch and decode
module fetch_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [XLEN-1:0]            in_inst_a,
  input  logic [XLEN-1:0]            in_pc_a,
  input  logic [XLEN-1:0]            in_inst_b,
  input  logic [XLEN-1:0]            in_pc_b,
  output logic                       in_ready,
  output logic                       out_valid_a,
  output logic [XLEN-1:0]            out_inst_a,
  output logic [XLEN-1:0]            out_pc_a,
  output logic                       out_valid_b,
  output logic [XLEN-1:0]            out_inst_b,
  output logic [XLEN-1:0]            out_pc_b,
  input  logic                       deq_a,
  input  logic                       deq_b,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, head_p1, tail_p1;
  logic [CW-1:0] count_q, count_d;
  logic a_nz, b_nz, do_enq;
  logic [1:0] enq, pop;
  // Occupancy, pointer advance and registered-state outputs; zero-inst slots are bubbles
  always_comb begin
    a_nz = in_inst_a != '0;
    b_nz = in_inst_b != '0;
    in_ready = count_q <= CW'(DEPTH-2);
    do_enq = in_valid & in_ready;
    enq = do_enq ? {1'b0, a_nz} + {1'b0, b_nz} : 2'd0;
    out_valid_a = count_q != '0;
    out_valid_b = count_q >= CW'(2);
    pop = (deq_a & out_valid_a) ? 2'd1 + {1'b0, deq_b & out_valid_b} : 2'd0;
    head_p1 = head_q + PW'(1);
    tail_p1 = tail_q + PW'(1);
    head_d = flush ? '0 : head_q + PW'(pop);
    tail_d = flush ? '0 : tail_q + PW'(enq);
    count_d = flush ? '0 : count_q + CW'(enq) - CW'(pop);
    out_inst_a = out_valid_a ? inst_mem[head_q] : '0;
    out_pc_a = out_valid_a ? pc_mem[head_q] : '0;
    out_inst_b = out_valid_b ? inst_mem[head_p1] : '0;
    out_pc_b = out_valid_b ? pc_mem[head_p1] : '0;
  end
  assign count = count_q;
  // Pointer and fill-count registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  // Storage write: slot b packs behind slot a, or into the tail if a was a bubble
  always_ff @(posedge clk) begin
    if (rst_n && !flush && do_enq) begin
      if (a_nz) begin
        inst_mem[tail_q] <= in_inst_a;
        pc_mem[tail_q] <= in_pc_a;
      end
      if (b_nz) begin
        inst_mem[a_nz ? tail_p1 : tail_q] <= in_inst_b;
        pc_mem[a_nz ? tail_p1 : tail_q] <= in_pc_b;
      end
    end
  end
  // Decode must only pop valid entries, and head+1 only together with head
  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      assert (!(deq_b && !deq_a));
      assert (!(deq_a && !out_valid_a));
      assert (!(deq_b && !out_valid_b));
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: scenario and randomized checks of fetch_buffer against a queue model
module tb_fetch_buffer;
  localparam int DEPTH = 8;
  localparam int XLEN = 32;
  localparam int CW = $clog2(DEPTH+1);
  typedef struct { logic [31:0] inst; logic [31:0] pc; } ent_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, deq_a = 0, deq_b = 0;
  logic [XLEN-1:0] in_inst_a = 0, in_pc_a = 0, in_inst_b = 0, in_pc_b = 0;
  logic in_ready, out_valid_a, out_valid_b;
  logic [XLEN-1:0] out_inst_a, out_pc_a, out_inst_b, out_pc_b;
  logic [CW-1:0] count;
  int n_cmp = 0, n_err = 0;
  ent_t q[$];

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_inst_a(in_inst_a), .in_pc_a(in_pc_a), .in_inst_b(in_inst_b), .in_pc_b(in_pc_b),
    .in_ready(in_ready), .out_valid_a(out_valid_a), .out_inst_a(out_inst_a), .out_pc_a(out_pc_a),
    .out_valid_b(out_valid_b), .out_inst_b(out_inst_b), .out_pc_b(out_pc_b),
    .deq_a(deq_a), .deq_b(deq_b), .count(count)
  );

  always #5 clk = ~clk;

  // Advance one clock and apply the queue semantics to the model using the inputs seen at the edge
  task automatic tick();
    int sz, np;
    bit rdy;
    @(posedge clk);
    sz = q.size();
    rdy = sz <= DEPTH - 2;
    if (!rst_n || flush) q.delete();
    else begin
      np = (deq_a && sz >= 1) ? 1 + int'(deq_b && sz >= 2) : 0;
      repeat (np) void'(q.pop_front());
      if (in_valid && rdy) begin
        if (in_inst_a != 0) q.push_back('{in_inst_a, in_pc_a});
        if (in_inst_b != 0) q.push_back('{in_inst_b, in_pc_b});
      end
    end
    #1;
  endtask

  task automatic drive_pair(input logic v, input logic [31:0] ia, pa, ib, pb);
    in_valid = v; in_inst_a = ia; in_pc_a = pa; in_inst_b = ib; in_pc_b = pb;
  endtask

  task automatic test_reset();
    rst_n = 0; drive_pair(0, 0, 0, 0, 0); tick(); rst_n = 1;
    n_cmp++; if (count !== 0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (in_ready !== 1) begin n_err++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid_a !== 0 || out_valid_b !== 0) begin n_err++; $display("FAIL reset_valid: got %b%b want 00", out_valid_a, out_valid_b); end
    n_cmp++; if ({out_inst_a, out_pc_a, out_inst_b, out_pc_b} !== 128'h0) begin n_err++; $display("FAIL reset_outs: got %h %h %h %h want 0", out_inst_a, out_pc_a, out_inst_b, out_pc_b); end
  endtask

  task automatic test_pair();
    drive_pair(1, 32'h00500093, 32'h0, 32'h00A00113, 32'h4); tick(); drive_pair(0, 0, 0, 0, 0);
    n_cmp++; if (count !== 2) begin n_err++; $display("FAIL pair_count: got %0d want 2", count); end
    n_cmp++; if (out_valid_a !== 1 || out_inst_a !== 32'h00500093 || out_pc_a !== 32'h0) begin n_err++; $display("FAIL pair_out_a: got %b %h %h want 1 00500093 0", out_valid_a, out_inst_a, out_pc_a); end
    n_cmp++; if (out_valid_b !== 1 || out_inst_b !== 32'h00A00113 || out_pc_b !== 32'h4) begin n_err++; $display("FAIL pair_out_b: got %b %h %h want 1 00a00113 4", out_valid_b, out_inst_b, out_pc_b); end
    deq_a = 1; deq_b = 1; tick(); deq_a = 0; deq_b = 0;
    n_cmp++; if (count !== 0 || out_valid_a !== 0) begin n_err++; $display("FAIL pair_drain: got count %0d valid %b want 0 0", count, out_valid_a); end
  endtask

  task automatic test_bubble();
    drive_pair(1, 32'h0, 32'h0, 32'h00100193, 32'h4); tick(); drive_pair(0, 0, 0, 0, 0);
    n_cmp++; if (count !== 1) begin n_err++; $display("FAIL bubble_count: got %0d want 1", count); end
    n_cmp++; if (out_inst_a !== 32'h00100193 || out_pc_a !== 32'h4) begin n_err++; $display("FAIL bubble_out_a: got %h %h want 00100193 4", out_inst_a, out_pc_a); end
    n_cmp++; if (out_valid_b !== 0 || out_inst_b !== 0 || out_pc_b !== 0) begin n_err++; $display("FAIL bubble_out_b: got %b %h %h want 0 0 0", out_valid_b, out_inst_b, out_pc_b); end
    deq_a = 1; tick(); deq_a = 0;
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 4; i++) begin
      drive_pair(1, 32'h1000 + 2*i, 32'h100 + 8*i, 32'h1001 + 2*i, 32'h104 + 8*i); tick();
    end
    n_cmp++; if (count !== 8 || in_ready !== 0) begin n_err++; $display("FAIL full_state: got count %0d ready %b want 8 0", count, in_ready); end
    drive_pair(1, 32'hDEAD0001, 32'h900, 32'hDEAD0002, 32'h904); tick(); drive_pair(0, 0, 0, 0, 0);
    n_cmp++; if (count !== 8 || out_pc_a !== 32'h100 || out_pc_b !== 32'h104) begin n_err++; $display("FAIL full_drop: got count %0d pcs %h %h want 8 100 104", count, out_pc_a, out_pc_b); end
    deq_a = 1; deq_b = 1; tick(); deq_a = 0; deq_b = 0;
    n_cmp++; if (count !== 6 || in_ready !== 1) begin n_err++; $display("FAIL full_release: got count %0d ready %b want 6 1", count, in_ready); end
    n_cmp++; if (out_inst_a !== 32'h1002 || out_pc_a !== 32'h108) begin n_err++; $display("FAIL full_head: got %h %h want 1002 108", out_inst_a, out_pc_a); end
    deq_a = 1; tick(); deq_a = 0;
    n_cmp++; if (count !== 5 || out_pc_a !== 32'h10C) begin n_err++; $display("FAIL full_single_deq: got count %0d pc %h want 5 10c", count, out_pc_a); end
  endtask

  task automatic test_flush();
    flush = 1; drive_pair(1, 32'h7777, 32'h500, 32'h8888, 32'h504); tick(); flush = 0; drive_pair(0, 0, 0, 0, 0);
    n_cmp++; if (count !== 0 || out_valid_a !== 0 || in_ready !== 1) begin n_err++; $display("FAIL flush_state: got count %0d valid %b ready %b want 0 0 1", count, out_valid_a, in_ready); end
    tick();
    n_cmp++; if (count !== 0 || out_valid_a !== 0) begin n_err++; $display("FAIL flush_nostore: got count %0d valid %b want 0 0", count, out_valid_a); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [31:0] pc_in, pc_out;
    pc_in = 32'h2000; pc_out = 32'h2000;
    drive_pair(1, 32'h13, pc_in, 32'h13, pc_in + 4); tick(); pc_in += 8;
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (count !== 2 || out_pc_a !== pc_out || out_pc_b !== pc_out + 4) begin n_err++; $display("FAIL wrap_step%0d: got count %0d pcs %h %h want 2 %h %h", i, count, out_pc_a, out_pc_b, pc_out, pc_out + 4); end
      pc_out += 8;
      drive_pair(1, 32'h13 + i, pc_in, 32'h93 + i, pc_in + 4); deq_a = 1; deq_b = 1; tick(); pc_in += 8;
    end
    drive_pair(0, 0, 0, 0, 0);
    n_cmp++; if (count !== 2 || out_pc_a !== pc_out) begin n_err++; $display("FAIL wrap_end: got count %0d pc %h want 2 %h", count, out_pc_a, pc_out); end
    tick(); deq_a = 0; deq_b = 0;
  endtask

  task automatic test_reset_mid();
    drive_pair(1, 32'h55, 32'h40, 32'h66, 32'h44); tick(); tick();
    rst_n = 0; tick(); rst_n = 1; drive_pair(0, 0, 0, 0, 0);
    n_cmp++; if (count !== 0 || out_valid_a !== 0 || in_ready !== 1) begin n_err++; $display("FAIL midreset: got count %0d valid %b ready %b want 0 0 1", count, out_valid_a, in_ready); end
    drive_pair(1, 32'hAB, 32'h80, 32'hCD, 32'h84); tick(); drive_pair(0, 0, 0, 0, 0);
    n_cmp++; if (count !== 2 || out_inst_a !== 32'hAB || out_inst_b !== 32'hCD) begin n_err++; $display("FAIL midreset_refill: got %0d %h %h want 2 ab cd", count, out_inst_a, out_inst_b); end
  endtask

  task automatic test_random();
    logic [31:0] pc, ea_i, ea_p, eb_i, eb_p;
    int sz;
    pc = 32'h4000;
    for (int i = 0; i < 400; i++) begin
      sz = q.size();
      ea_i = sz >= 1 ? q[0].inst : 0; ea_p = sz >= 1 ? q[0].pc : 0;
      eb_i = sz >= 2 ? q[1].inst : 0; eb_p = sz >= 2 ? q[1].pc : 0;
      n_cmp++;
      if (count !== CW'(sz) || in_ready !== (sz <= DEPTH - 2) || out_valid_a !== (sz >= 1) || out_valid_b !== (sz >= 2) ||
          out_inst_a !== ea_i || out_pc_a !== ea_p || out_inst_b !== eb_i || out_pc_b !== eb_p) begin
        n_err++;
        $display("FAIL rand_cyc%0d: got c=%0d r=%b v=%b%b a=%h/%h b=%h/%h want c=%0d a=%h/%h b=%h/%h",
                 i, count, in_ready, out_valid_a, out_valid_b, out_inst_a, out_pc_a, out_inst_b, out_pc_b, sz, ea_i, ea_p, eb_i, eb_p);
      end
      drive_pair($urandom_range(0, 2) != 0, ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1), pc,
                 ($urandom_range(0, 3) == 0) ? 32'h0 : ($urandom | 32'h1), pc + 4);
      deq_a = (sz >= 1) && ($urandom_range(0, 2) != 0);
      deq_b = deq_a && (sz >= 2) && $urandom_range(0, 1) == 1;
      flush = $urandom_range(0, 39) == 0;
      rst_n = !($urandom_range(0, 99) == 0);
      if (in_valid && in_ready) pc += 8;
      tick();
    end
    rst_n = 1; flush = 0; deq_a = 0; deq_b = 0; drive_pair(0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_pair();
    test_bubble();
    test_full_stall();
    test_flush();
    test_back_to_back_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
